// File: rtl/fsmoe_pkg.sv
// ============================================================================
// Module : fsmoe_pkg
// Brief  : Shared constants and state encoding for the fsmoe block family.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fsmoe_pkg;

    localparam int FSMOE_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

endpackage : fsmoe_pkg

`default_nettype wire

// File: rtl/fsmoe_bit_serializer.sv
// ============================================================================
// Module : fsmoe_bit_serializer
// Brief  : Valid/ready word-to-bit serializer feeding the fsmoe x input.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fsmoe_bit_serializer
    import fsmoe_pkg::*;
#(
    parameter int WIDTH      = FSMOE_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP_CYCLES = 0,
    parameter bit IDLE_BIT   = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             flush,
    output logic             x_out,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy,
    output logic [7:0]       word_count
);

    localparam int         CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] BIT_PENULT = CNT_W'(WIDTH - 2);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    ser_state_e        state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [3:0]        gap_cnt_q, gap_cnt_d;
    logic [7:0]        word_count_q, word_count_d;
    logic              x_out_q, x_out_d;
    logic              x_valid_q, x_valid_d;
    logic              last_bit_q, last_bit_d;

    logic              w_first_bit;
    logic [WIDTH-1:0]  w_loaded;
    logic              w_next_bit;
    logic [WIDTH-1:0]  w_shifted;
    logic              w_terminal;
    logic              w_accept;
    logic              w_load;

    // shreg holds only the bits still to be sent; x_out_q carries the live bit
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_first_bit = in_data[WIDTH-1];
            assign w_loaded    = {in_data[WIDTH-2:0], 1'b0};
            assign w_next_bit  = shreg_q[WIDTH-1];
            assign w_shifted   = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_first_bit = in_data[0];
            assign w_loaded    = {1'b0, in_data[WIDTH-1:1]};
            assign w_next_bit  = shreg_q[0];
            assign w_shifted   = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        w_terminal = 1'b0;
        if (GAP_CYCLES > 0) begin
            w_terminal = (state_q == ST_GAP) && (gap_cnt_q == GAP_LAST);
        end else begin
            w_terminal = (state_q == ST_SHIFT) && last_bit_q;
        end
    end

    assign in_ready = !flush && ((state_q == ST_IDLE) || w_terminal);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        word_count_d = word_count_q;
        x_out_d      = IDLE_BIT;
        x_valid_d    = 1'b0;
        last_bit_d   = 1'b0;
        w_load       = 1'b0;

        if (flush) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    w_load = w_accept;
                end
                ST_SHIFT: begin
                    if (last_bit_q) begin
                        word_count_d = word_count_q + 8'd1;
                        if (GAP_CYCLES > 0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = '0;
                        end else if (w_accept) begin
                            w_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        x_out_d    = w_next_bit;
                        x_valid_d  = 1'b1;
                        shreg_d    = w_shifted;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        last_bit_d = (bit_cnt_q == BIT_PENULT);
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_d = '0;
                        if (w_accept) begin
                            w_load = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (w_load) begin
                state_d    = ST_SHIFT;
                shreg_d    = w_loaded;
                bit_cnt_d  = '0;
                x_out_d    = w_first_bit;
                x_valid_d  = 1'b1;
                last_bit_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            word_count_q <= '0;
            x_out_q      <= IDLE_BIT;
            x_valid_q    <= 1'b0;
            last_bit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            word_count_q <= word_count_d;
            x_out_q      <= x_out_d;
            x_valid_q    <= x_valid_d;
            last_bit_q   <= last_bit_d;
        end
    end

    assign x_out      = x_out_q;
    assign x_valid    = x_valid_q;
    assign last_bit   = last_bit_q;
    assign busy       = (state_q != ST_IDLE);
    assign word_count = word_count_q;

endmodule : fsmoe_bit_serializer

`default_nettype wire
